sys_reg_file: RTL
=================

Name: sys_reg_file

Overview:
- Single-port register file directly downstream of the system controller, in the i_Ref_clk domain.
- Accepts the controller's write strobe, read strobe, address and write data; returns read data with a valid pulse for FIFO forwarding.
- Exports four dedicated registers continuously:
  - REG0: ALU operand A
  - REG1: ALU operand B
  - REG2: UART config
  - REG3: clock-divider ratio

Parameters:
- WIDTH_REG, 8, data width of each register.
- ADDR, 4, address width; DEPTH = 2**ADDR registers.
- REG2_RST, 8'b1000_0001, reset value of REG2 (prescale 32, parity enable, even parity).
- REG3_RST, 8'd32, reset value of REG3 (divide ratio).

Ports:
- i_Ref_clk  in  1  system reference clock, all logic on rising edge.
- i_rst  in  1  asynchronous active-low reset.
- i_wr_en  in  1  write strobe, sampled each rising edge.
- i_rd_en  in  1  read strobe, sampled each rising edge.
- i_addr  in  ADDR  register address for read or write.
- i_wr_data  in  WIDTH_REG  write data.
- o_rd_data  out  WIDTH_REG  registered read data.
- o_rd_valid  out  1  high for the cycle o_rd_data holds a fresh read result.
- o_REG0  out  WIDTH_REG  contents of address 0 (ALU operand A).
- o_REG1  out  WIDTH_REG  contents of address 1 (ALU operand B).
- o_REG2  out  WIDTH_REG  contents of address 2 (UART config).
- o_REG3  out  WIDTH_REG  contents of address 3 (divider ratio).

Behaviour:
- Clock i_Ref_clk; reset i_rst, asynchronous, active-low. All state updates on i_Ref_clk rising edge.
- Reset values:
  - Every register is 0, except addr 2 = REG2_RST and addr 3 = REG3_RST.
  - o_rd_data = 0, o_rd_valid = 0.
- Write (i_wr_en=1, i_rd_en=0): mem[i_addr] <= i_wr_data at the edge. The new value appears on o_REGn the same edge (1-cycle latency from strobe). o_rd_valid = 0 that cycle.
- Read (i_rd_en=1, i_wr_en=0): o_rd_data <= mem[i_addr] and o_rd_valid <= 1 at the edge. Latency is 1 cycle.
- Held read strobe: if i_rd_en stays high, o_rd_valid stays high every cycle and o_rd_data tracks the current i_addr. This supports the controller's read-hold while the FIFO is full.
- Idle or no read: o_rd_valid <= 0 on every edge without a read. o_rd_data holds its last value; it is not cleared.
- Simultaneous i_wr_en=1 and i_rd_en=1: the write executes and the read is ignored. o_rd_valid <= 0 and o_rd_data holds.
- Read-after-write to the same address on the next cycle returns the new data, because the write has completed in the array.
- Address range: all 2**ADDR addresses are valid, so no out-of-range case exists. Writes to addr 0-3 update the dedicated outputs; writes to addr 4+ affect only readback.
- o_REG0..o_REG3 are direct register outputs with no combinational path from the inputs.
- Reset asserted mid-operation:
  - All registers, o_rd_data and o_rd_valid return to reset values immediately (asynchronous).
  - A pending strobe in that cycle is lost.
  - After deassertion, the first edge behaves normally.
- X-safety: when neither strobe is asserted, i_addr and i_wr_data are don't-care and must not alter state.

Test Plan:
- Reset: pulse i_rst low mid-cycle -> immediately o_REG0=0, o_REG1=0, o_REG2=8'h81, o_REG3=8'h20, o_rd_valid=0, o_rd_data=0.
- Write then read: wr addr 5 data 8'hA5; next cycle rd addr 5 -> one edge later o_rd_data=8'hA5, o_rd_valid=1 for exactly one cycle, then 0.
- Operand path: wr addr 0 = 8'd12, wr addr 1 = 8'd7 on consecutive cycles -> o_REG0=12 after the first edge, o_REG1=7 after the second. o_REG2 and o_REG3 unchanged.
- Simultaneous strobes: wr_en=rd_en=1, addr 3, data 8'h10 -> o_REG3=8'h10, o_rd_valid=0, o_rd_data unchanged. A following read of addr 3 returns 8'h10.
- Held read: rd_en high 4 cycles while addr steps 3, 2, 3, 15 -> o_rd_valid high 4 consecutive cycles, data = 8'h20, 8'h81, 8'h20, 0.
- Reset mid-operation: write 8'hFF to addr 2, then assert i_rst while rd_en=1 -> o_REG2 returns to 8'h81 and o_rd_valid=0 during reset. After release, reading addr 2 returns 8'h81.

Source files
------------

// File: rtl/sys_reg_file.sv
// sys_reg_file: single-port register file behind the system controller.
// Address 0..3 are exported continuously as ALU operands, UART config and
// clock-divider ratio; every address can be read back with a valid pulse.
module sys_reg_file #(
  parameter int unsigned          WIDTH_REG = 8,
  parameter int unsigned          ADDR      = 4,
  parameter logic [WIDTH_REG-1:0] REG2_RST  = 8'b1000_0001,
  parameter logic [WIDTH_REG-1:0] REG3_RST  = 8'd32
) (
  input  logic                 i_Ref_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_en,
  input  logic                 i_rd_en,
  input  logic [ADDR-1:0]      i_addr,
  input  logic [WIDTH_REG-1:0] i_wr_data,
  output logic [WIDTH_REG-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic [WIDTH_REG-1:0] o_REG0,
  output logic [WIDTH_REG-1:0] o_REG1,
  output logic [WIDTH_REG-1:0] o_REG2,
  output logic [WIDTH_REG-1:0] o_REG3
);

  localparam int unsigned DEPTH = 2 ** ADDR;

  logic [WIDTH_REG-1:0] mem [DEPTH];
  logic [WIDTH_REG-1:0] rd_data;
  logic                 rd_valid;

  // Register array plus read port; a write wins over a simultaneous read.
  always_ff @(posedge i_Ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i == 2)
          mem[i[ADDR-1:0]] <= REG2_RST;
        else if (i == 3)
          mem[i[ADDR-1:0]] <= REG3_RST;
        else
          mem[i[ADDR-1:0]] <= '0;
      end
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (i_wr_en) begin
        mem[i_addr] <= i_wr_data;
      end else if (i_rd_en) begin
        rd_data  <= mem[i_addr];
        rd_valid <= 1'b1;
      end
    end
  end

  // Dedicated registers are driven straight from the array flops.
  always_comb begin
    o_REG0     = mem[0];
    o_REG1     = mem[1];
    o_REG2     = mem[2];
    o_REG3     = mem[3];
    o_rd_data  = rd_data;
    o_rd_valid = rd_valid;
  end

endmodule
